tcn_to_7seg_driver: RTL and testbench
=====================================

// Module: tcn_to_7seg_driver
// PURPOSE
//   Registered, parametrised two's-complement to signed-decimal 7-segment driver.
//   - Converts a WIDTH-bit two's-complement value into one sign display plus DIGITS
//     magnitude displays. Conversion is a sequential shift-add-3 (double dabble).
//   - Optional leading-zero blanking. Drives the board HEX displays, active low.
//   - Successor to the 4-bit combinational look-up converter.
// PARAMETERS
//   WIDTH    8  bit width of input N (two's complement), 2..16
//   DIGITS   3  number of magnitude displays; must satisfy 10**DIGITS > 2**(WIDTH-1)
//               (elaboration error otherwise)
//   BLANK_LZ 1  1: leading zero digits off (7'h7F); 0: leading zeros shown as '0'
// PORTS
//   Clock      in   1          rising-edge clock
//   Resetn     in   1          asynchronous reset, active low
//   N          in   WIDTH      two's-complement value, sampled when Load accepted
//   Load       in   1          start-conversion request, single-cycle strobe
//   Busy       out  1          1 while a conversion is in progress
//   Done       out  1          one-cycle pulse when displays are updated
//   Sign       out  7          sign display, active low {g,f,e,d,c,b,a}
//   Magnitude  out  7*DIGITS   digit k at [7k+6:7k], k=0 least significant, active low
// BEHAVIOUR
//   Reset (Resetn=0, async): state IDLE; Busy=0; Done=0; Sign=7'h7F;
//     Magnitude = all 7'h7F; internal registers cleared.
//   States and transitions:
//     IDLE -> CONV: on Load=1. Capture sgn=N[WIDTH-1] and
//       mag = sgn ? (~N+1) : N as WIDTH-bit unsigned.
//       -2**(WIDTH-1) gives mag=2**(WIDTH-1), which fits. bcd=0, cnt=0.
//     CONV: one bit per cycle, WIDTH cycles.
//       Per cycle: every BCD nibble >=5 gets +3, then {bcd,mag} <<= 1.
//       After cnt reaches WIDTH-1 -> UPD.
//     UPD: encode bcd nibbles to segments, register Sign/Magnitude, Done=1 -> IDLE.
//   Latency: Load sampled at edge t -> Done=1 and new outputs visible after edge
//     t+WIDTH+1; Busy=1 from edge t through edge t+WIDTH+1.
//   Outputs hold their last value between conversions; they change only in UPD.
//   Load while Busy=1: ignored, not queued; the running conversion is unaffected.
//   Load in the UPD cycle: ignored. Load in the cycle after Done is accepted.
//   Segment codes (active low):
//     0=1000000 1=1111001 2=0100100 3=0110000 4=0011001
//     5=0010010 6=0000010 7=1111000 8=0000000 9=0010000
//   Sign: 7'b0111111 (segment g only) if sgn=1, else 7'h7F.
//   Blanking (BLANK_LZ=1): a digit is 7'h7F if it and all more significant digits
//     are 0; digit 0 is never blanked (value 0 shows '0').
//   Zero is never negative: N=0 -> Sign=7'h7F.
//   Resetn asserted mid-conversion: immediate return to reset values, no Done
//     pulse; a new Load is needed after release.
//   N may change freely while Busy; only the value captured at Load is converted.
// TESTING (WIDTH=8, DIGITS=3, BLANK_LZ=1 unless noted)
//   1. Reset release, no Load -> Sign=7F, Magnitude all 7F, Busy=0, Done=0 indefinitely.
//   2. Load N=8'h00 -> Done exactly 9 cycles later; Sign=7F; digits {7F,7F,1000000}.
//   3. Load N=8'h80 (-128) -> Sign=0111111; digits {1111001,0100100,0000000} = "-128".
//   4. Load N=8'h7F, then N=8'hFF -> "127" with Sign=7F; then "-1": Sign=0111111,
//      digits {7F,7F,1111001}.
//   5. Load 8'h05, re-assert Load with 8'h63 at cycle 3 -> second Load ignored,
//      result "5", Busy never drops early, one Done pulse only.
//   6. Resetn low at cycle 4 of a conversion -> outputs 7F at once, no Done;
//      BLANK_LZ=0, N=8'hF9 -> digits {1000000,1000000,1111000}, Sign=0111111 ("-007").

Source files
------------

// File: rtl/tcn_to_7seg_if.sv
// Load/result bus between a requester and the two's-complement to 7-segment driver.
interface tcn_to_7seg_if #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned DIGITS = 3
);
  logic [WIDTH-1:0]    N;
  logic                Load;
  logic                Busy;
  logic                Done;
  logic [6:0]          Sign;
  logic [7*DIGITS-1:0] Magnitude;

  modport master (output N, Load, input Busy, Done, Sign, Magnitude);
  modport slave  (input N, Load, output Busy, Done, Sign, Magnitude);
endinterface

// File: rtl/tcn_to_7seg_driver.sv
// Sequential double-dabble converter: WIDTH-bit two's complement to a sign display
// plus DIGITS active-low decimal digits, optional leading-zero blanking.
module tcn_to_7seg_driver #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned DIGITS   = 3,
  parameter int unsigned BLANK_LZ = 1
) (
  input logic           Clock,
  input logic           Resetn,
  tcn_to_7seg_if.slave  bus
);

  localparam int unsigned BCD_W = 4 * DIGITS;
  localparam int unsigned SEG_W = 7 * DIGITS;
  localparam int unsigned CNT_W = $clog2(WIDTH);

  function automatic longint unsigned pow10(input int unsigned e);
    longint unsigned r = 1;
    for (int unsigned i = 0; i < e; i++) r = r * 10;
    return r;
  endfunction

  if (WIDTH < 2 || WIDTH > 16) begin : g_bad_width
    $error("tcn_to_7seg_driver: WIDTH must be in 2..16");
  end
  if (pow10(DIGITS) <= (64'd1 << (WIDTH - 1))) begin : g_bad_digits
    $error("tcn_to_7seg_driver: DIGITS too small for WIDTH");
  end

  typedef enum logic [1:0] {S_IDLE, S_CONV, S_UPD} state_e;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0: seg7 = 7'b1000000;
      4'd1: seg7 = 7'b1111001;
      4'd2: seg7 = 7'b0100100;
      4'd3: seg7 = 7'b0110000;
      4'd4: seg7 = 7'b0011001;
      4'd5: seg7 = 7'b0010010;
      4'd6: seg7 = 7'b0000010;
      4'd7: seg7 = 7'b1111000;
      4'd8: seg7 = 7'b0000000;
      4'd9: seg7 = 7'b0010000;
      default: seg7 = 7'h7F;
    endcase
  endfunction

  state_e             state_q, state_d;
  logic               sgn_q, sgn_d;
  logic [WIDTH-1:0]   mag_q, mag_d;
  logic [BCD_W-1:0]   bcd_q, bcd_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [6:0]         sign_q, sign_d;
  logic [SEG_W-1:0]   magn_q, magn_d;
  logic [BCD_W-1:0]   bcd_adj;
  logic               lead;

  always_comb begin
    state_d = state_q;
    sgn_d   = sgn_q;
    mag_d   = mag_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    sign_d  = sign_q;
    magn_d  = magn_q;
    bcd_adj = bcd_q;
    lead    = 1'b1;
    unique case (state_q)
      S_IDLE: begin
        if (bus.Load) begin
          state_d = S_CONV;
          sgn_d   = bus.N[WIDTH-1];
          mag_d   = bus.N[WIDTH-1] ? WIDTH'(~bus.N + WIDTH'(1)) : bus.N;
          bcd_d   = '0;
          cnt_d   = '0;
          busy_d  = 1'b1;
        end
      end
      S_CONV: begin
        // Add-3 correction on every nibble, then shift the next magnitude bit in.
        for (int k = 0; k < int'(DIGITS); k++) begin
          if (bcd_adj[4*k+:4] >= 4'd5) bcd_adj[4*k+:4] = bcd_adj[4*k+:4] + 4'd3;
        end
        bcd_d = {bcd_adj[BCD_W-2:0], mag_q[WIDTH-1]};
        mag_d = {mag_q[WIDTH-2:0], 1'b0};
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) state_d = S_UPD;
      end
      S_UPD: begin
        sign_d = (sgn_q && (bcd_q != '0)) ? 7'b0111111 : 7'h7F;
        // Walk from the most significant digit, blanking while only zeros seen.
        for (int k = int'(DIGITS) - 1; k >= 0; k--) begin
          lead = lead && (bcd_q[4*k+:4] == 4'd0);
          if (BLANK_LZ != 0 && lead && k != 0) magn_d[7*k+:7] = 7'h7F;
          else                                  magn_d[7*k+:7] = seg7(bcd_q[4*k+:4]);
        end
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q <= S_IDLE;
      sgn_q   <= 1'b0;
      mag_q   <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sign_q  <= 7'h7F;
      magn_q  <= {DIGITS{7'h7F}};
    end else begin
      state_q <= state_d;
      sgn_q   <= sgn_d;
      mag_q   <= mag_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      sign_q  <= sign_d;
      magn_q  <= magn_d;
    end
  end

  assign bus.Busy      = busy_q;
  assign bus.Done      = done_q;
  assign bus.Sign      = sign_q;
  assign bus.Magnitude = magn_q;

endmodule

// File: tb/tb_tcn_to_7seg_driver.sv
// Bench for tcn_to_7seg_driver: blanking and non-blanking instances share stimulus and
// are checked every cycle against a decimal-arithmetic model plus literal expectations.
module tb_tcn_to_7seg_driver;

  localparam int unsigned W = 8;
  localparam int unsigned D = 3;
  localparam logic [6:0]  SEG [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                       7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  logic         clk;
  logic         rst_n;
  logic [W-1:0] n_in;
  logic         load_in;
  int           n_chk  = 0;
  int           n_fail = 0;
  int           done_cnt = 0;

  tcn_to_7seg_if #(.WIDTH(W), .DIGITS(D)) if_a ();
  tcn_to_7seg_if #(.WIDTH(W), .DIGITS(D)) if_b ();

  assign if_a.N    = n_in;
  assign if_a.Load = load_in;
  assign if_b.N    = n_in;
  assign if_b.Load = load_in;

  tcn_to_7seg_driver #(.WIDTH(W), .DIGITS(D), .BLANK_LZ(1)) dut_a (
    .Clock(clk), .Resetn(rst_n), .bus(if_a));
  tcn_to_7seg_driver #(.WIDTH(W), .DIGITS(D), .BLANK_LZ(0)) dut_b (
    .Clock(clk), .Resetn(rst_n), .bus(if_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic logic [6:0] exp_sign(input bit has, input int v);
    return (has && v < 0) ? 7'h3F : 7'h7F;
  endfunction

  function automatic logic [7*D-1:0] exp_mag(input bit has, input int v, input bit blank);
    logic [7*D-1:0] r;
    int a;
    int p = 1;
    r = {D{7'h7F}};
    if (!has) return r;
    a = (v < 0) ? -v : v;
    for (int k = 0; k < int'(D); k++) begin
      r[7*k+:7] = (blank && k > 0 && a < p) ? 7'h7F : SEG[(a / p) % 10];
      p = p * 10;
    end
    return r;
  endfunction

  // Model: a conversion accepted at an edge shows its result WIDTH+1 edges later.
  int m_left  = 0;
  int m_val   = 0;
  int m_shown = 0;
  bit m_has   = 1'b0;
  bit m_done  = 1'b0;

  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      m_left = 0; m_done = 1'b0; m_has = 1'b0;
    end else begin
      m_done = 1'b0;
      if (m_left > 0) begin
        m_left--;
        if (m_left == 0) begin
          m_done = 1'b1; m_has = 1'b1; m_shown = m_val;
        end
      end else if (load_in) begin
        m_val  = int'($signed(n_in));
        m_left = int'(W) + 1;
      end
    end
    check("busy_a", 32'(if_a.Busy), 32'(m_left > 0));
    check("busy_b", 32'(if_b.Busy), 32'(m_left > 0));
    check("done_a", 32'(if_a.Done), 32'(m_done));
    check("done_b", 32'(if_b.Done), 32'(m_done));
    check("sign_a", 32'(if_a.Sign), 32'(exp_sign(m_has, m_shown)));
    check("sign_b", 32'(if_b.Sign), 32'(exp_sign(m_has, m_shown)));
    check("mag_a", 32'(if_a.Magnitude), 32'(exp_mag(m_has, m_shown, 1'b1)));
    check("mag_b", 32'(if_b.Magnitude), 32'(exp_mag(m_has, m_shown, 1'b0)));
    if (if_a.Done === 1'b1) done_cnt++;
  end

  // Issue one Load and wait (bounded) for Done on the blanking instance.
  task automatic run_load(input logic [W-1:0] v);
    int cyc = 0;
    @(negedge clk); #1 n_in = v; load_in = 1'b1;
    @(negedge clk); #1 load_in = 1'b0;
    while (cyc < 20) begin
      @(negedge clk);
      cyc++;
      if (if_a.Done === 1'b1) break;
    end
    check("latency", 32'(cyc), 32'd9);
  endtask

  task automatic check_out(input string nm, input logic [6:0] s_a, input logic [7*D-1:0] m_a,
                           input logic [6:0] s_b, input logic [7*D-1:0] m_b);
    check({nm, "_sign_a"}, 32'(if_a.Sign), 32'(s_a));
    check({nm, "_mag_a"},  32'(if_a.Magnitude), 32'(m_a));
    check({nm, "_sign_b"}, 32'(if_b.Sign), 32'(s_b));
    check({nm, "_mag_b"},  32'(if_b.Magnitude), 32'(m_b));
  endtask

  int d0;

  initial begin
    rst_n = 1'b1; n_in = '0; load_in = 1'b0;
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b1;

    // Idle after reset: blank displays, no activity.
    repeat (6) @(negedge clk);
    #1;
    check_out("reset", 7'h7F, {3{7'h7F}}, 7'h7F, {3{7'h7F}});
    check("reset_busy", 32'(if_a.Busy), 32'd0);
    check("reset_done", 32'(if_a.Done), 32'd0);

    run_load(8'h00);
    check_out("zero", 7'h7F, {7'h7F, 7'h7F, 7'h40}, 7'h7F, {7'h40, 7'h40, 7'h40});

    run_load(8'h80);
    check_out("m128", 7'h3F, {7'h79, 7'h24, 7'h00}, 7'h3F, {7'h79, 7'h24, 7'h00});

    run_load(8'h7F);
    check_out("p127", 7'h7F, {7'h79, 7'h24, 7'h78}, 7'h7F, {7'h79, 7'h24, 7'h78});

    run_load(8'hFF);
    check_out("m1", 7'h3F, {7'h7F, 7'h7F, 7'h79}, 7'h3F, {7'h40, 7'h40, 7'h79});

    run_load(8'h64);
    check_out("p100", 7'h7F, {7'h79, 7'h40, 7'h40}, 7'h7F, {7'h79, 7'h40, 7'h40});

    run_load(8'hF6);
    check_out("m10", 7'h3F, {7'h7F, 7'h79, 7'h40}, 7'h3F, {7'h40, 7'h79, 7'h40});

    // Second Load during a conversion must be dropped; N may wander while busy.
    d0 = done_cnt;
    @(negedge clk); #1 n_in = 8'h05; load_in = 1'b1;
    @(negedge clk); #1 load_in = 1'b0;
    repeat (2) @(negedge clk);
    #1 n_in = 8'h63; load_in = 1'b1;
    @(negedge clk); #1 load_in = 1'b0; n_in = 8'hAA;
    repeat (14) @(negedge clk);
    #1;
    check("ignored_load_dones", 32'(done_cnt - d0), 32'd1);
    check_out("p5", 7'h7F, {7'h7F, 7'h7F, 7'h12}, 7'h7F, {7'h40, 7'h40, 7'h12});

    // Reset in the middle of a conversion: immediate blank, no Done afterwards.
    d0 = done_cnt;
    @(negedge clk); #1 n_in = 8'h2A; load_in = 1'b1;
    @(negedge clk); #1 load_in = 1'b0;
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check_out("midrst", 7'h7F, {3{7'h7F}}, 7'h7F, {3{7'h7F}});
    check("midrst_busy", 32'(if_a.Busy), 32'd0);
    check("midrst_done", 32'(if_a.Done), 32'd0);
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    repeat (12) @(negedge clk);
    #1;
    check("midrst_no_done", 32'(done_cnt - d0), 32'd0);

    run_load(8'hF9);
    check_out("m7", 7'h3F, {7'h7F, 7'h7F, 7'h78}, 7'h3F, {7'h40, 7'h40, 7'h78});

    repeat (3) @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
